fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC register, IDLE/RUN/HALTED control FSM, retired-instruction counter
module fetch_unit #(
    parameter int         PW        = 10,
    parameter logic [8:0] HALT_WORD = 9'b110_000000,
    parameter logic [8:0] NOP_WORD  = 9'b101_000000
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic [7:0]    BranchOffset,
    input  logic [8:0]    InstrIn,
    output logic [PW-1:0] PcOut,
    output logic [8:0]    Instruction,
    output logic          InstrValid,
    output logic          Done,
    output logic [15:0]   InstrCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] OP_BEQ = 3'b101;

    state_t              r_state;
    state_t              w_next_state;
    logic [PW-1:0]       r_pc;
    logic [PW-1:0]       w_next_pc;
    logic [15:0]         r_count;
    logic [15:0]         w_next_count;
    logic                w_retire;
    logic signed [7:0]   w_offset_s;
    logic [PW-1:0]       w_offset;

    // Sign-extending size cast; PC arithmetic then wraps naturally mod 2**PW.
    assign w_offset_s = BranchOffset;
    assign w_offset   = PW'(w_offset_s);

    assign w_retire    = (r_state == S_RUN) && !Stall;
    assign InstrValid  = w_retire;
    assign Instruction = (r_state == S_RUN) ? InstrIn : NOP_WORD;
    assign Done        = (r_state == S_HALTED);
    assign PcOut       = r_pc;
    assign InstrCount  = r_count;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                w_next_pc = '0;
                if (Start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_retire) begin
                    if (r_count != 16'hFFFF) begin
                        w_next_count = r_count + 16'd1;
                    end
                    // The halt keeps its own address on PcOut while Done is up.
                    if (InstrIn == HALT_WORD) begin
                        w_next_state = S_HALTED;
                    end else if ((InstrIn[8:6] == OP_BEQ) && BranchTaken) begin
                        w_next_pc = r_pc + w_offset;
                    end else begin
                        w_next_pc = r_pc + 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (Start) begin
                    w_next_state = S_RUN;
                    w_next_pc    = '0;
                    w_next_count = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_pc    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_count <= w_next_count;
        end
    end

endmodule
